inst_encoder_packer: RTL and testbench
======================================

# inst_encoder_packer

Instruction encoder and packer: the write-side counterpart of the instruction decode path. It takes decoded instruction fields (type, opcode, funct3/funct7, register numbers, immediate) and encodes each into a 32-bit RV64 word. It packs two words per 64-bit bus beat, with a valid/ready handshake on both sides. It sits between the instruction-generation/test-stimulus logic and the memory write port. Malformed requests are dropped and counted.

## Interface
- `BUS_DATA_WIDTH`, 64: output beat width; holds two 32-bit instructions.
- `TYPE_WIDTH`, 3: width of the instruction-type code; values are the `*_TYPE` macros of instruction_types.defs.
- `REGISTER_WIDTH`, 5: register-number width.
- `IMMEDIATE_WIDTH`, 32: immediate input width.
- `ERR_COUNT_WIDTH`, 8: width of the saturating error counter.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted this cycle when high together with `in_valid`.
- `in_type` in TYPE_WIDTH: `R_TYPE`/`I_TYPE`/`S_TYPE`/`SB_TYPE`/`U_TYPE`/`UJ_TYPE`; any other value is unknown.
- `in_opcode` in 7, `in_funct3` in 3, `in_funct7` in 7: encoding fields.
- `in_rd`, `in_rs1`, `in_rs2` in REGISTER_WIDTH: register numbers.
- `in_imm` in IMMEDIATE_WIDTH: sign-extended byte immediate; for shifts the caller places shamt and funct bits in imm[11:0].
- `flush` in 1: emit a half-filled beat.
- `out_valid` out 1: beat present.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out BUS_DATA_WIDTH: [31:0] holds the older instruction, [63:32] the younger.
- `out_mask` out 2: bit0 means the low half is valid; bit1 means the high half is valid.
- `err_count` out ERR_COUNT_WIDTH: number of dropped requests; saturates.

## Operation
Encoding is combinational from the inputs:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}

Drop rule:
- An accepted request is dropped if its type is unknown, or if it is SB/UJ with imm[0]=1.
- A dropped request consumes the handshake but does not change the packer state.
- A dropped request increments `err_count`, which saturates at all-ones and clears only on reset.

Packer states:
- EMPTY: `out_valid`=0. A good accept writes the low half and moves to HALF. `flush` is ignored.
- HALF: `out_valid`=0.
  - A good accept writes the high half and moves to FULL with `out_mask`=11.
  - `flush` without a good accept zeroes the high half and moves to FULL with `out_mask`=01.
  - `flush` together with a good accept behaves as a plain accept, giving mask 11.
- FULL: `out_valid`=1, `out_data` and `out_mask` held stable.
  - On `out_ready` with a good accept: the new word goes to the low half and the state moves to HALF.
  - On `out_ready` without a good accept: the state moves to EMPTY.
  - Without `out_ready`: the state stays FULL. `flush` is ignored.

Handshake rules:
- `in_ready` = (state != FULL) | `out_ready`. It is combinational from state and `out_ready`, and has no dependence on `in_valid`.
- `in_ready` does not drop for requests that will be dropped; they are always consumed when `in_ready` is high.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `out_data`=0, `out_mask`=00, `err_count`=0, `in_ready`=1.
- Reset asserted mid-operation discards any held or partial beat immediately (asynchronous).
- Latency: the beat is visible the cycle after the second instruction is accepted, or the cycle after `flush` in HALF.
- Throughput: one instruction per cycle sustained with `out_ready`=1. Accept and drain in the same cycle never stall.
- `out_data`/`out_mask` must not change while `out_valid`=1 and `out_ready`=0.
- `err_count` updates the cycle after the dropped accept.

## Test plan
- Encode and pack a pair: ADD x3,x1,x2 (R, op 0x33), then ADDI x1,x0,5 (I, op 0x13, f3 0), with `out_ready`=1.
  - Required: one beat, `out_data`=0x00500093_002081B3, `out_mask`=11.
- Encode S, SB and U forms in sequence: SD x2,8(x1) (S, op 0x23, f3 3); BEQ x0,x0,-4 (SB, op 0x63); LUI x5,0x12345 (imm 0x12345000, op 0x37); then `flush`.
  - Required: beat 1 `out_data`=0xFE000EE3_0020B423 with mask 11.
  - Required: beat 2 `out_data`=0x00000000_123452B7 with mask 01.
- Backpressure: hold `out_ready`=0 with FULL and issue a third request.
  - Required: `in_ready`=0 and `out_data` stable.
  - Raise `out_ready`: the beat drains and the third word lands in the low half in the same cycle, with the state going to HALF.
- Bad requests:
  - Unknown type: dropped, `err_count` 0 -> 1.
  - BEQ with imm=3: dropped, `err_count` -> 2.
  - Neither bad request changes `out_mask` or the state.
  - 300 bad requests: `err_count` saturates at 255.
- Flush corner cases:
  - `flush` in EMPTY: no beat.
  - `flush` in the same cycle as the second accept: a single mask-11 beat.
- Reset asserted asynchronously while in HALF and again while in FULL: all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/inst_encoder_packer.sv
// ---------------------------------------------------------------------------
// inst_encoder_packer
//
// Encodes decoded RV64 instruction fields into 32-bit instruction words and
// packs them two per 64-bit bus beat. Malformed requests (unknown type, or a
// branch/jump immediate that is not 2-byte aligned) are consumed but dropped,
// and a saturating counter records how many were dropped.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous, active-low reset
//   in_valid   - request present
//   in_ready   - request accepted when high together with in_valid
//   in_type    - instruction type code (R/I/S/SB/U/UJ, others unknown)
//   in_opcode, in_funct3, in_funct7 - encoding fields
//   in_rd, in_rs1, in_rs2           - register numbers
//   in_imm     - sign-extended immediate (shamt/funct bits in imm[11:0] for shifts)
//   flush      - emit a half-filled beat
//   out_valid  - beat present
//   out_ready  - consumer accepts the beat
//   out_data   - [31:0] older instruction, [63:32] younger instruction
//   out_mask   - bit0 low half valid, bit1 high half valid
//   err_count  - number of dropped requests, saturating
// ---------------------------------------------------------------------------
module inst_encoder_packer #(
  parameter int BUS_DATA_WIDTH  = 64,
  parameter int TYPE_WIDTH      = 3,
  parameter int REGISTER_WIDTH  = 5,
  parameter int IMMEDIATE_WIDTH = 32,
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TYPE_WIDTH-1:0]      in_type,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [REGISTER_WIDTH-1:0]  in_rd,
  input  logic [REGISTER_WIDTH-1:0]  in_rs1,
  input  logic [REGISTER_WIDTH-1:0]  in_rs2,
  input  logic [IMMEDIATE_WIDTH-1:0] in_imm,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BUS_DATA_WIDTH-1:0]  out_data,
  output logic [1:0]                 out_mask,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
);

  // Instruction type codes shared with the instruction-generation side.
  localparam logic [TYPE_WIDTH-1:0] R_TYPE  = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] I_TYPE  = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] S_TYPE  = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] SB_TYPE = TYPE_WIDTH'(3);
  localparam logic [TYPE_WIDTH-1:0] U_TYPE  = TYPE_WIDTH'(4);
  localparam logic [TYPE_WIDTH-1:0] UJ_TYPE = TYPE_WIDTH'(5);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HALF,
    ST_FULL
  } state_t;

  state_t      state, next_state;
  logic [31:0] lo_word, hi_word;
  logic [31:0] enc_word;
  logic        type_known, is_bad, accept, good_accept, drop_accept;
  logic        load_lo, load_hi, clear_hi;
  logic [1:0]  next_mask;

  // Combinational encoding of the request fields into one instruction word.
  always_comb begin
    enc_word   = 32'd0;
    type_known = 1'b1;
    case (in_type)
      R_TYPE:  enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      I_TYPE:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      S_TYPE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      SB_TYPE: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
      U_TYPE:  enc_word = {in_imm[31:12], in_rd, in_opcode};
      UJ_TYPE: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: type_known = 1'b0;
    endcase
  end

  // Branch and jump targets drop imm[0], so an odd offset cannot be encoded.
  assign is_bad      = !type_known || (((in_type == SB_TYPE) || (in_type == UJ_TYPE)) && in_imm[0]);
  assign in_ready    = (state != ST_FULL) || out_ready;
  assign accept      = in_valid && in_ready;
  assign good_accept = accept && !is_bad;
  assign drop_accept = accept && is_bad;

  assign out_valid = (state == ST_FULL);
  assign out_data  = {hi_word, lo_word};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= next_state;
  end

  // Next-state and half-load decisions. Draining a full beat and accepting
  // a new word in the same cycle restarts the next beat in its low half.
  always_comb begin
    next_state = state;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    clear_hi   = 1'b0;
    next_mask  = out_mask;
    case (state)
      ST_EMPTY: begin
        if (good_accept) begin
          load_lo    = 1'b1;
          next_state = ST_HALF;
        end
      end
      ST_HALF: begin
        if (good_accept) begin
          load_hi    = 1'b1;
          next_mask  = 2'b11;
          next_state = ST_FULL;
        end else if (flush) begin
          clear_hi   = 1'b1;
          next_mask  = 2'b01;
          next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (good_accept) begin
            load_lo    = 1'b1;
            next_state = ST_HALF;
          end else begin
            next_state = ST_EMPTY;
          end
        end
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // Beat data and mask; held untouched while a full beat waits for the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_word  <= 32'd0;
      hi_word  <= 32'd0;
      out_mask <= 2'b00;
    end else begin
      out_mask <= next_mask;
      if (load_lo)  lo_word <= enc_word;
      if (load_hi)  hi_word <= enc_word;
      if (clear_hi) hi_word <= 32'd0;
    end
  end

  // Saturating count of dropped requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (drop_accept && (err_count != {ERR_COUNT_WIDTH{1'b1}})) begin
      err_count <= err_count + ERR_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder_packer.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder_packer
//
// Self-checking bench for inst_encoder_packer. A queue-based reference model
// tracks pending instruction words and the beat on offer; outputs are sampled
// on the falling clock edge. Directed steps reproduce the worked examples,
// followed by randomized traffic and an error-counter saturation run.
// ---------------------------------------------------------------------------
module tb_inst_encoder_packer;

  localparam logic [2:0] R_T  = 3'd0;
  localparam logic [2:0] I_T  = 3'd1;
  localparam logic [2:0] S_T  = 3'd2;
  localparam logic [2:0] SB_T = 3'd3;
  localparam logic [2:0] U_T  = 3'd4;
  localparam logic [2:0] UJ_T = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  out_mask;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pend[$];
  bit          m_full;
  logic [63:0] m_beat;
  logic [1:0]  m_mask;
  int          m_err;

  inst_encoder_packer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [2:0] t, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'd0;
    if (t == R_T)       w = {f7, rs2, rs1, f3, rd, op};
    else if (t == I_T)  w = {imm[11:0], rs1, f3, rd, op};
    else if (t == S_T)  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    else if (t == SB_T) w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    else if (t == U_T)  w = {imm[31:12], rd, op};
    else if (t == UJ_T) w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    return w;
  endfunction

  function automatic bit ref_bad(input logic [2:0] t, input logic [31:0] imm);
    return (t > UJ_T) || (((t == SB_T) || (t == UJ_T)) && imm[0]);
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_full = 1'b0;
    m_beat = 64'd0;
    m_mask = 2'b00;
    m_err  = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", {63'd0, out_valid}, {63'd0, m_full});
    check("err_count", {56'd0, err_count}, 64'(m_err));
    if (m_full) begin
      check("out_data", out_data, m_beat);
      check("out_mask", {62'd0, out_mask}, {62'd0, m_mask});
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check in_ready, advance
  // the model across the rising edge and check outputs at the next falling edge.
  task automatic step(input bit v, input logic [2:0] t, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input bit fl, input bit ordy);
    bit rdy, acc, bad, was_half;
    in_valid = v; in_type = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; flush = fl; out_ready = ordy;
    rdy = !m_full || ordy;
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    @(posedge clk);
    acc      = v && rdy;
    bad      = ref_bad(t, imm);
    was_half = !m_full && (m_pend.size() == 1);
    if (m_full && ordy) m_full = 1'b0;
    if (acc && bad) m_err = (m_err < 255) ? m_err + 1 : 255;
    if (acc && !bad) begin
      m_pend.push_back(ref_encode(t, op, f3, f7, rd, rs1, rs2, imm));
      if (m_pend.size() == 2) begin
        m_beat = {m_pend[1], m_pend[0]};
        m_mask = 2'b11;
        m_full = 1'b1;
        m_pend.delete();
      end
    end else if (fl && was_half) begin
      m_beat = {32'd0, m_pend[0]};
      m_mask = 2'b01;
      m_full = 1'b1;
      m_pend.delete();
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, R_T, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ordy);
  endtask

  task automatic async_reset_check(input string tag);
    in_valid = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_mask"}, {62'd0, out_mask}, 64'd0);
    check({tag, "_err"}, {56'd0, err_count}, 64'd0);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_mask", {62'd0, out_mask}, 64'd0);
    check("rst_err", {56'd0, err_count}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    @(negedge clk);

    // ADD x3,x1,x2 then ADDI x1,x0,5
    step(1, R_T, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1);
    step(1, I_T, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 1);
    check("pair_data", out_data, 64'h00500093_002081B3);
    check("pair_mask", {62'd0, out_mask}, 64'd3);

    // SD, BEQ, LUI, flush
    step(1, S_T, 7'h23, 3'd3, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 1);
    step(1, SB_T, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 0, 1);
    check("beat1_data", out_data, 64'hFE000EE3_0020B423);
    check("beat1_mask", {62'd0, out_mask}, 64'd3);
    step(1, U_T, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 0, 1);
    step(0, R_T, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0);
    check("beat2_data", out_data, 64'h00000000_123452B7);
    check("beat2_mask", {62'd0, out_mask}, 64'd1);
    idle(1);

    // Backpressure: third request stalls, then drains and lands in the same cycle
    step(1, R_T, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0, 0, 0);
    step(1, R_T, 7'h33, 3'd0, 7'h20, 5'd7, 5'd8, 5'd9, 32'd0, 0, 0);
    step(1, I_T, 7'h13, 3'd0, 7'd0, 5'd10, 5'd11, 5'd0, 32'd77, 0, 0);
    check("bp_ready", {63'd0, in_ready}, 64'd0);
    check("bp_stable", out_data, m_beat);
    step(1, I_T, 7'h13, 3'd0, 7'd0, 5'd10, 5'd11, 5'd0, 32'd77, 0, 1);
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    step(0, R_T, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1);
    check("bp_half_mask", {62'd0, out_mask}, 64'd1);
    idle(1);

    // Bad requests
    step(1, 3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 0, 1);
    check("bad_unknown", {56'd0, err_count}, 64'd1);
    step(1, SB_T, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 0, 1);
    check("bad_beq", {56'd0, err_count}, 64'd2);
    check("bad_no_beat", {63'd0, out_valid}, 64'd0);

    // Flush corners
    step(0, R_T, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1);
    check("flush_empty", {63'd0, out_valid}, 64'd0);
    step(1, U_T, 7'h17, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hABCD_E000, 0, 1);
    step(1, UJ_T, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0010, 1, 0);
    check("flush_accept_mask", {62'd0, out_mask}, 64'd3);
    idle(1);

    // Async reset in HALF and in FULL
    step(1, R_T, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 0);
    async_reset_check("arst_half");
    step(1, R_T, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 0);
    step(1, I_T, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0);
    async_reset_check("arst_full");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  t;
      logic [31:0] imm;
      t   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
      step($urandom_range(0, 3) != 0, t, 7'($urandom), 3'($urandom), 7'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), imm,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      step(1, 3'd6, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1);
    end
    check("err_saturated", {56'd0, err_count}, 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
